// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS symbol types and blanking control codes
package tmds_pkg;
    typedef logic [9:0] tmds_sym_t;
    typedef logic [8:0] qm_t;
    localparam tmds_sym_t CTRL_SYM [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
endpackage

// File: rtl/tmds_qm_stage.sv
// tmds_qm_stage: transition-minimising XOR/XNOR choice for one byte
import tmds_pkg::*;
module tmds_qm_stage (
    input  logic [7:0] d,
    output qm_t        qm
);
    logic [3:0] n;
    logic       xn;
    always_comb begin
        n = 4'($countones(d));
        xn = n > 4'd4 || (n == 4'd4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ xn;
        qm[8] = ~xn;
    end
endmodule

// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe: two-stage multi-channel TMDS 8b/10b encoder with DC balancing
import tmds_pkg::*;
module tmds_encoder_pipe #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_in,
    input  logic                     de_in,
    input  logic [2*NUM_CH-1:0]      ctrl_in,
    input  logic [8*NUM_CH-1:0]      data_in,
    output logic                     valid_out,
    output logic [10*NUM_CH-1:0]     tmds_out,
    output logic [DISP_W*NUM_CH-1:0] disp_out
);
    localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);
    localparam logic signed [DISP_W-1:0] ZERO = '0;
    qm_t [NUM_CH-1:0]          qm_c, qm_r;
    logic                      v_r, de_r;
    logic [2*NUM_CH-1:0]       ctrl_r;
    logic [10*NUM_CH-1:0]      sym_c;
    logic [DISP_W*NUM_CH-1:0]  cnt_c;
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [DISP_W-1:0] cnt, diff, nxt;
        logic                     bal, flip, q8;
        logic [7:0]               q;
        tmds_sym_t                s;
        tmds_qm_stage u_qm (.d(data_in[8*k +: 8]), .qm(qm_c[k]));
        // diff is n1-n0 of q_m[7:0]; cnt is the disparity left by this channel's last symbol
        always_comb begin
            q = qm_r[k][7:0];
            q8 = qm_r[k][8];
            cnt = $signed(disp_out[DISP_W*k +: DISP_W]);
            diff = DISP_W'(2 * $countones(q) - 8);
            bal = cnt == 0 || diff == 0;
            flip = (cnt > 0 && diff > 0) || (cnt < 0 && diff < 0);
            s = !de_r ? CTRL_SYM[ctrl_r[2*k +: 2]] : bal ? {~q8, q8, q8 ? q : ~q} : flip ? {1'b1, q8, ~q} : {1'b0, q8, q};
            nxt = !de_r ? ZERO : bal ? (q8 ? cnt + diff : cnt - diff) : flip ? cnt + (q8 ? TWO : ZERO) - diff : cnt + diff - (q8 ? ZERO : TWO);
        end
        assign sym_c[10*k +: 10] = s;
        assign cnt_c[DISP_W*k +: DISP_W] = nxt;
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            v_r <= 1'b0;
            de_r <= 1'b0;
            ctrl_r <= '0;
            qm_r <= '0;
            valid_out <= 1'b0;
            tmds_out <= '0;
            disp_out <= '0;
        end else begin
            v_r <= valid_in;
            valid_out <= v_r;
            if (valid_in) begin
                de_r <= de_in;
                ctrl_r <= ctrl_in;
                qm_r <= qm_c;
            end
            if (v_r) begin
                tmds_out <= sym_c;
                disp_out <= cnt_c;
            end
        end
    end
endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb_tmds_encoder_pipe: directed and random checks of the TMDS encoder against a symbol-level model
module tb_tmds_encoder_pipe;
    localparam int NC = 3;
    localparam int DW = 5;
    logic clk_in = 0, rst_in = 0, valid_in = 0, de_in = 0;
    logic [2*NC-1:0] ctrl_in = '0;
    logic [8*NC-1:0] data_in = '0;
    logic valid_out;
    logic [10*NC-1:0] tmds_out;
    logic [DW*NC-1:0] disp_out;
    int total = 0, bad = 0;
    tmds_encoder_pipe #(.NUM_CH(NC), .DISP_W(DW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .de_in(de_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(valid_out),
        .tmds_out(tmds_out), .disp_out(disp_out)
    );
    always #5 clk_in = ~clk_in;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask
    // encode from the rules: pick the inversion that pulls the disparity toward zero,
    // then the new disparity is simply the running sum of (ones - zeros) of what was sent
    function automatic void enc(input int cnt, input logic de, input logic [1:0] c, input logic [7:0] d,
                                output logic [9:0] s, output int nc);
        logic [8:0] q;
        logic xn, inv;
        int diff;
        logic [9:0] cs [4];
        cs = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        if (!de) begin
            s = cs[c];
            nc = 0;
            return;
        end
        xn = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        diff = 2 * $countones(q[7:0]) - 8;
        inv = (cnt == 0 || diff == 0) ? !q[8] : ((cnt > 0) == (diff > 0));
        s = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
        nc = cnt + 2 * $countones(s) - 10;
    endfunction
    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
        return d;
    endfunction
    int mcnt [NC];
    logic p1_v, o_v, p1_de, o_de;
    logic [9:0] p1_s [NC], o_s [NC];
    int p1_c [NC], o_c [NC];
    logic [7:0] p1_d [NC], o_d [NC];
    logic lit_h = 0, lit_v = 0, l1_h, l1_v, lo_h, lo_v;
    logic [9:0] lit_s = '0, l1_s, lo_s;
    logic [DW-1:0] lit_d = '0, l1_d, lo_d;
    always @(posedge clk_in) begin
        if (!rst_in) begin
            p1_v = 0; o_v = 0; l1_h = 0; lo_h = 0;
            for (int k = 0; k < NC; k++) begin
                mcnt[k] = 0; o_s[k] = 0; o_c[k] = 0;
            end
        end else begin
            o_v = p1_v;
            if (p1_v) begin
                o_de = p1_de;
                o_s = p1_s; o_c = p1_c; o_d = p1_d;
            end
            {lo_h, lo_v, lo_s, lo_d} = {l1_h, l1_v, l1_s, l1_d};
            {l1_h, l1_v, l1_s, l1_d} = {lit_h, lit_v, lit_s, lit_d};
            p1_v = valid_in;
            if (valid_in) begin
                p1_de = de_in;
                for (int k = 0; k < NC; k++) begin
                    enc(mcnt[k], de_in, ctrl_in[2*k +: 2], data_in[8*k +: 8], p1_s[k], mcnt[k]);
                    p1_c[k] = mcnt[k];
                    p1_d[k] = data_in[8*k +: 8];
                end
            end
        end
    end
    int ed, a;
    always @(posedge clk_in) begin
        #1;
        check("valid", valid_out, o_v);
        for (int k = 0; k < NC; k++) begin
            ed = o_c[k];
            check($sformatf("sym%0d", k), tmds_out[10*k +: 10], o_s[k]);
            check($sformatf("disp%0d", k), disp_out[DW*k +: DW], ed[DW-1:0]);
            if (o_v && o_de) begin
                a = int'($signed(disp_out[DW*k +: DW]));
                check($sformatf("range%0d", k), a >= -10 && a <= 10, 1);
                check($sformatf("decode%0d", k), dec(tmds_out[10*k +: 10]), o_d[k]);
            end
        end
        if (lo_h) begin
            check("lit_valid", valid_out, lo_v);
            check("lit_sym", tmds_out[9:0], lo_s);
            check("lit_disp", disp_out[DW-1:0], lo_d);
        end
    end
    task automatic drive(input logic v, input logic de, input logic [2*NC-1:0] c, input logic [8*NC-1:0] d,
                         input logic h, input logic ev, input logic [9:0] es, input int e);
        @(negedge clk_in);
        rst_in = 1; valid_in = v; de_in = de; ctrl_in = c; data_in = d;
        lit_h = h; lit_v = ev; lit_s = es; lit_d = e[DW-1:0];
    endtask
    task automatic dd(input logic v, input logic de, input logic [1:0] c, input logic [7:0] d,
                      input logic [9:0] es, input int e);
        drive(v, de, {NC{c}}, {NC{d}}, 1, v, es, e);
    endtask
    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, 0);
    endtask
    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 0; valid_in = 1; de_in = 1; data_in = 24'hA5C33C; lit_h = 0;
        @(posedge clk_in);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_disp", disp_out, 0);
        check("rst_sym", tmds_out, 0);
    endtask
    logic [9:0] ts;
    int tc;
    initial begin
        enc(0, 1, 2'b00, 8'h00, ts, tc); check("pin_s0", ts, 10'h100); check("pin_c0", tc, -8);
        enc(-8, 1, 2'b00, 8'h00, ts, tc); check("pin_s1", ts, 10'h3FF); check("pin_c1", tc, 2);
        enc(-8, 1, 2'b00, 8'hFF, ts, tc); check("pin_s2", ts, 10'h0FF); check("pin_c2", tc, -2);
        enc(5, 0, 2'b10, 8'h00, ts, tc); check("pin_s3", ts, 10'h154); check("pin_c3", tc, 0);
        do_reset();
        dd(1, 1, 0, 8'h00, 10'h100, -8);
        dd(1, 1, 0, 8'h00, 10'h3FF, 2);
        idle(); idle();
        do_reset();
        dd(1, 1, 0, 8'hFF, 10'h200, -8);
        dd(1, 1, 0, 8'hFF, 10'h0FF, -2);
        idle(); idle();
        dd(1, 0, 0, 8'h00, 10'h354, 0);
        dd(1, 0, 1, 8'h00, 10'h0AB, 0);
        dd(1, 0, 2, 8'h00, 10'h154, 0);
        dd(1, 0, 3, 8'h00, 10'h2AB, 0);
        dd(1, 1, 0, 8'h00, 10'h100, -8);
        idle(); idle();
        dd(1, 1, 0, 8'h00, 10'h3FF, 2);
        dd(0, 1, 0, 8'h00, 10'h3FF, 2);
        dd(1, 1, 0, 8'h00, 10'h100, -6);
        idle(); idle();
        drive(1, 1, '0, '0, 0, 0, '0, 0);
        do_reset();
        dd(1, 1, 0, 8'h00, 10'h100, -8);
        idle(); idle();
        for (int n = 0; n < 3000; n++)
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, (2*NC)'($urandom), (8*NC)'($urandom), 0, 0, '0, 0);
        idle(); idle(); idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
